button_event_decoder: RTL and testbench

- Sits directly downstream of the debouncer.
- Consumes the clean, debounced switch level and classifies user gestures into single-cycle event pulses: press, release, short press, long press and double click.
- Feeds the control/UI logic, which then never deals with raw switch timing.
- Fully synchronous; one clock domain shared with the debouncer.

---
 rtl/btn_event_pkg.sv | 20 ++
 rtl/btn_edge_detect.sv | 50 +++++
 rtl/button_event_decoder.sv | 153 +++++++++++++++
 tb/tb_button_event_decoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the button event decoder: gesture FSM state
// encoding and a constant max function used for counter sizing.
package btn_event_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } btn_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Polarity normalisation and press/release edge detection on the debounced level.
// Registered outputs for the ports, same-cycle _c outputs for the gesture FSM.
module btn_edge_detect
  import btn_event_pkg::*;
#(
  parameter bit IS_PULLUP = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sig,
  output logic o_pressed,
  output logic o_press,
  output logic o_release,
  output logic o_pressed_c,
  output logic o_press_c,
  output logic o_release_c
);

  logic pressed_q, pressed_d;
  logic press_q, press_d;
  logic release_q, release_d;

  // pressed_q doubles as the previous-level register; resets to released
  assign o_pressed_c = i_sig ^ IS_PULLUP;
  assign o_press_c   = o_pressed_c & ~pressed_q;
  assign o_release_c = ~o_pressed_c & pressed_q;

  always_comb begin
    pressed_d = o_pressed_c;
    press_d   = o_press_c;
    release_d = o_release_c;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_pressed = pressed_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into single-cycle event pulses.
// Optional auto-repeat while long-held is enabled by defining BTN_AUTO_REPEAT_EN.
module button_event_decoder
  import btn_event_pkg::*;
#(
  parameter bit          IS_PULLUP     = 1'b1,
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned DCLICK_CYCLES = 300,
  parameter int unsigned REPEAT_CYCLES = 100
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sig_debounced,
  output logic o_pressed,
  output logic o_press,
  output logic o_release,
  output logic o_short_press,
  output logic o_long_press,
  output logic o_double_click,
  output logic o_repeat,
  output logic o_busy
);

  localparam int unsigned CNT_W = $clog2(max3(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be >= 2");
  end
  if (DCLICK_CYCLES < 1) begin : g_bad_dclick
    $error("DCLICK_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 1");
  end

  logic pressed_c, press_c, release_c;

  btn_edge_detect #(.IS_PULLUP(IS_PULLUP)) u_edge (
    .clk        (clk),
    .rstn       (rstn),
    .i_sig      (i_sig_debounced),
    .o_pressed  (o_pressed),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_pressed_c(pressed_c),
    .o_press_c  (press_c),
    .o_release_c(release_c)
  );

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             busy_q, busy_d;
  logic             cnt_restart;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic rep_q, rep_d;
`endif

  // Counter value k-1 at the k-th edge after state entry; release/press checked first
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    short_d     = 1'b0;
    long_d      = 1'b0;
    dbl_d       = 1'b0;
    cnt_restart = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    rep_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (press_c) state_d = PRESSED;
      end
      PRESSED: begin
        if (release_c) begin
          state_d = WAIT_SECOND;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (release_c) begin
          state_d = IDLE;
        end
`ifdef BTN_AUTO_REPEAT_EN
        else if (cnt_q == REPEAT_LAST) begin
          rep_d       = 1'b1;
          cnt_restart = 1'b1;
        end
`endif
      end
      WAIT_SECOND: begin
        if (press_c) begin
          state_d = SECOND_PRESSED;
        end else if (cnt_q == DCLICK_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      SECOND_PRESSED: begin
        if (release_c) begin
          dbl_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_d != state_q) || cnt_restart) cnt_d = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!rstn) rep_q <= 1'b0;
    else       rep_q <= rep_d;
  end
  assign o_repeat = rep_q;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_short_press  = short_q;
  assign o_long_press   = long_q;
  assign o_double_click = dbl_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: timestamp-based gesture model
// compared every cycle, plus hand-computed literal expectations per scenario.
module tb_button_event_decoder;

  localparam int unsigned L = 20;
  localparam int unsigned D = 8;
  localparam int unsigned R = 5;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic i_sig;
  logic o_pressed, o_press, o_release, o_short_press, o_long_press;
  logic o_double_click, o_repeat, o_busy;

  always #5 clk = ~clk;

  button_event_decoder #(
    .IS_PULLUP    (1'b1),
    .LONG_CYCLES  (L),
    .DCLICK_CYCLES(D),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_sig_debounced(i_sig),
    .o_pressed      (o_pressed),
    .o_press        (o_press),
    .o_release      (o_release),
    .o_short_press  (o_short_press),
    .o_long_press   (o_long_press),
    .o_double_click (o_double_click),
    .o_repeat       (o_repeat),
    .o_busy         (o_busy)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  // gesture model: timestamps of the current gesture's events
  bit m_pp, g_on, g_up, g_second, g_long;
  int t_press, t_rel, t_long;
  bit e_pressed, e_press, e_rel, e_short, e_long, e_dbl, e_rep, e_busy;

  // observed pulse tallies
  int n_press, n_rel, n_short, n_long, n_dbl, n_rep;
  int to_press, to_rel, to_short, to_long, to_dbl;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, exp, t);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b edge=%0d", name, act, exp, t);
    end
  endtask

  task automatic model(input logic lvl, input logic rn);
    bit p;
    p = !lvl;
    {e_pressed, e_press, e_rel, e_short, e_long, e_dbl, e_rep, e_busy} = '0;
    if (!rn) begin
      m_pp = 1'b0;
      g_on = 1'b0;
      return;
    end
    e_pressed = p;
    e_press   = p && !m_pp;
    e_rel     = !p && m_pp;
    if (!g_on) begin
      if (e_press) begin
        g_on = 1'b1; g_up = 1'b0; g_second = 1'b0; g_long = 1'b0; t_press = t;
      end
    end else if (g_long) begin
      if (e_rel) g_on = 1'b0;
      else e_rep = REP_EN && ((t - t_long) % R == 0);
    end else if (!g_up && !g_second) begin
      if (e_rel) begin
        g_up = 1'b1; t_rel = t;
      end else if (t - t_press == L) begin
        e_long = 1'b1; g_long = 1'b1; t_long = t;
      end
    end else if (g_up) begin
      if (p) begin
        g_up = 1'b0; g_second = 1'b1;
      end else if (t - t_rel == D) begin
        e_short = 1'b1; g_on = 1'b0;
      end
    end else if (e_rel) begin
      e_dbl = 1'b1; g_on = 1'b0;
    end
    m_pp   = p;
    e_busy = g_on;
  endtask

  // one clock: drive, advance model at the edge, compare 1 time unit later
  task automatic tick(input logic lvl, input logic rn);
    i_sig = lvl;
    rstn  = rn;
    @(posedge clk);
    t++;
    model(lvl, rn);
    #1;
    checkb("o_pressed", o_pressed, e_pressed);
    checkb("o_press", o_press, e_press);
    checkb("o_release", o_release, e_rel);
    checkb("o_short_press", o_short_press, e_short);
    checkb("o_long_press", o_long_press, e_long);
    checkb("o_double_click", o_double_click, e_dbl);
    checkb("o_repeat", o_repeat, e_rep);
    checkb("o_busy", o_busy, e_busy);
    if (o_press)        begin n_press++; to_press = t; end
    if (o_release)      begin n_rel++;   to_rel   = t; end
    if (o_short_press)  begin n_short++; to_short = t; end
    if (o_long_press)   begin n_long++;  to_long  = t; end
    if (o_double_click) begin n_dbl++;   to_dbl   = t; end
    if (o_repeat)       n_rep++;
  endtask

  task automatic run(input logic lvl, input logic rn, input int n);
    for (int i = 0; i < n; i++) tick(lvl, rn);
  endtask

  task automatic clear_tally();
    {n_press, n_rel, n_short, n_long, n_dbl, n_rep} = '0;
    {to_press, to_rel, to_short, to_long, to_dbl} = '0;
  endtask

  initial begin
    clear_tally();
    // reset with button released, then release reset: no events
    run(1'b1, 1'b0, 10);
    checkb("reset_busy", o_busy, 1'b0);
    clear_tally();
    run(1'b1, 1'b1, 3);
    check("post_reset_press", n_press, 0);

    // short click
    clear_tally();
    run(1'b0, 1'b1, 5);
    run(1'b1, 1'b1, 12);
    check("short_n_press", n_press, 1);
    check("short_n_release", n_rel, 1);
    check("short_hold_len", to_rel - to_press, 5);
    check("short_n_short", n_short, 1);
    check("short_gap", to_short - to_rel, 8);
    check("short_n_long", n_long, 0);
    check("short_n_dbl", n_dbl, 0);

    // long hold: low on edges n..n+40
    clear_tally();
    run(1'b0, 1'b1, 41);
    run(1'b1, 1'b1, 12);
    check("long_n_long", n_long, 1);
    check("long_gap", to_long - to_press, 20);
    check("long_n_release", n_rel, 1);
    check("long_n_short", n_short, 0);
    check("long_n_repeat", n_rep, REP_EN ? 4 : 0);

    // double click
    clear_tally();
    run(1'b0, 1'b1, 4);
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 4);
    run(1'b1, 1'b1, 12);
    check("dbl_n_press", n_press, 2);
    check("dbl_n_dbl", n_dbl, 1);
    check("dbl_on_release", to_dbl - to_rel, 0);
    check("dbl_n_short", n_short, 0);

    // release exactly at press edge + 20 takes the short path
    clear_tally();
    run(1'b0, 1'b1, 20);
    run(1'b1, 1'b1, 12);
    check("bnd_hold_len", to_rel - to_press, 20);
    check("bnd_n_long", n_long, 0);
    check("bnd_n_short", n_short, 1);

    // second press exactly at release edge + 8 is a double click
    clear_tally();
    run(1'b0, 1'b1, 4);
    run(1'b1, 1'b1, 8);
    run(1'b0, 1'b1, 3);
    run(1'b1, 1'b1, 12);
    check("bnd2_n_dbl", n_dbl, 1);
    check("bnd2_n_short", n_short, 0);

    // reset while in the second press
    clear_tally();
    run(1'b0, 1'b1, 4);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 3);
    checkb("mid_busy_before", o_busy, 1'b1);
    tick(1'b0, 1'b0);
    checkb("mid_busy_reset", o_busy, 1'b0);
    run(1'b1, 1'b0, 3);
    clear_tally();
    run(1'b1, 1'b1, 10);
    check("mid_n_press", n_press, 0);
    check("mid_n_release", n_rel, 0);
    check("mid_n_short", n_short, 0);
    check("mid_n_dbl", n_dbl, 0);

    // button held through reset: press at first post-reset edge
    run(1'b0, 1'b0, 3);
    clear_tally();
    tick(1'b0, 1'b1);
    check("held_rst_press", n_press, 1);
    run(1'b0, 1'b1, 3);
    run(1'b1, 1'b1, 12);
    check("held_rst_short", n_short, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
